tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter DIV_W, default 24: width of each channel's divide register and down-counter.
REQ-002 Parameter VGA_DIV, default 3: reset divide value of channel 0 (vga); the period is VGA_DIV+1 cycles.
REQ-003 Parameter SEG_DIV, default 262143: reset divide value of channel 1 (seg).
REQ-004 Parameter LOGIC_DIV, default 4194303: reset divide value of channel 2 (logic).
REQ-005 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 cmd_start  input  1  single-cycle pulse: begin, or restart, ticking.
REQ-008 cmd_stop  input  1  single-cycle pulse: return to IDLE.
REQ-009 cmd_pause  input  1  single-cycle pulse: freeze the counters.
REQ-010 cmd_resume  input  1  single-cycle pulse: continue from the frozen counts.
REQ-011 cfg_valid  input  1  configuration write request.
REQ-012 cfg_ready  output  1  configuration write can be accepted.
REQ-013 cfg_ch  input  2  target channel, 0..2; the value 3 is invalid.
REQ-014 cfg_div  input  DIV_W  new divide value.
REQ-015 cfg_err  output  1  one-cycle pulse when a write targets channel 3.
REQ-016 tick_vga, tick_seg, tick_logic  output  1 each  registered one-cycle enable pulses.
REQ-017 logic_ticks  output  16  count of tick_logic pulses since the last start.
REQ-018 state  output  2  encoding: IDLE=0, RUN=1, PAUSE=2.

Function
REQ-019 Each channel i SHALL hold a register div[i] and a down-counter cnt[i], both DIV_W bits wide.
REQ-020 State transitions SHALL be:
- IDLE --start--> RUN
- RUN --pause--> PAUSE
- PAUSE --resume--> RUN
- RUN/PAUSE --stop--> IDLE
- RUN/PAUSE --start--> RUN, with restart
REQ-021 When several commands are sampled in the same cycle, priority SHALL be stop > start > pause > resume; only the highest-priority command takes effect.
REQ-022 A command that is not legal in the current state SHALL be ignored: pause in IDLE or PAUSE, resume in IDLE or RUN, stop in IDLE.
REQ-023 On any start, including a restart, cnt[i] SHALL load div[i] and logic_ticks SHALL clear to 0.
REQ-024 In IDLE, cnt[i] SHALL track div[i], and all ticks SHALL be 0.
REQ-025 In RUN, at each edge, per channel:
- if cnt[i]==0, then cnt[i]<=div[i] and tick[i]<=1;
- otherwise cnt[i]<=cnt[i]-1 and tick[i]<=0.
REQ-026 Tick latency: with start high in cycle 0, the first tick SHALL be high in cycle div+2; every following tick SHALL occur every div+1 cycles.
REQ-027 div[i]=0 SHALL make tick[i] continuously high from cycle 2 while in RUN.
REQ-028 In PAUSE, cnt[i] SHALL hold, and ticks SHALL be 0 from the cycle after pause is sampled.
REQ-029 On resume, counting SHALL continue from the held cnt[i], so total period is preserved, excluding paused cycles.
REQ-030 After stop, all ticks SHALL be 0 from the cycle after stop is sampled.
REQ-031 Config handshake:
- a write is accepted when cfg_valid && cfg_ready at an edge;
- cfg_ready SHALL be low for exactly the one cycle following an acceptance, and high otherwise after reset.
REQ-032 An accepted write with cfg_ch<=2 SHALL update div[cfg_ch] at that edge.
REQ-033 In RUN and PAUSE, the new divide value SHALL take effect at that channel's next reload; the current cnt is not disturbed.
REQ-034 A write accepted in the same cycle as a sampled start SHALL have its new value used for the start load.
REQ-035 An accepted write with cfg_ch==3 SHALL change no div register and SHALL pulse cfg_err high for one cycle.
REQ-036 logic_ticks SHALL increment on each edge where tick_logic is registered high, and SHALL wrap from 65535 to 0.
REQ-037 Ticks of different channels SHALL be independent and MAY coincide in the same cycle.

Reset
REQ-038 Asserting reset SHALL immediately force all of the following, regardless of the clock:
- state=IDLE;
- div[0..2]=VGA_DIV, SEG_DIV, LOGIC_DIV;
- cnt[i]=div[i];
- all ticks=0, cfg_err=0, logic_ticks=0;
- cfg_ready=0 while reset is asserted, and 1 from the first edge after release.
REQ-039 Reset asserted mid-RUN or mid-handshake SHALL discard pending work; no tick or cfg_err SHALL be emitted from pre-reset state.

Verification
REQ-040 Default vga period: start in cycle 0 -> tick_vga high in cycles 5, 9, 13, ...; state=1 from cycle 1.
REQ-041 Pause and resume: write div[0]=7, start, pause after the first tick, hold 10 cycles, resume -> gaps between tick_vga pulses are 8 cycles, excluding paused cycles; no ticks while state=2.
REQ-042 Handshake: cfg_valid held high for 3 cycles with ch=0 -> writes accepted in cycles 0 and 2; cfg_ready=0 in cycles 1 and 3. A write to ch=3 -> cfg_err pulses once and div is unchanged.
REQ-043 Command collisions: stop+start in the same cycle while in RUN -> IDLE and no ticks. start+cfg to ch=0 div=1 -> first tick_vga in cycle 3.
REQ-044 Reset mid-RUN with tick_logic imminent -> no tick, logic_ticks=0, default divs restored, cfg_ready=1 after release.
REQ-045 Wrap: write div[2]=0, run 65537 cycles after the first tick -> logic_ticks wraps to 0 and then reads 1.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Three-channel programmable tick generator (vga, seg, logic). Each channel
//   owns a divide register and a down-counter; while running, a channel emits
//   a one-cycle registered tick every div+1 cycles. A small command FSM
//   (IDLE/RUN/PAUSE) starts, stops, pauses and resumes all channels together,
//   and a valid/ready port rewrites divide values on the fly.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   cmd_start    pulse: start, or restart, ticking
//   cmd_stop     pulse: return to IDLE
//   cmd_pause    pulse: freeze the counters
//   cmd_resume   pulse: continue from the frozen counts
//   cfg_valid    configuration write request
//   cfg_ready    configuration write can be accepted
//   cfg_ch       target channel 0..2 (3 is invalid)
//   cfg_div      new divide value
//   cfg_err      one-cycle pulse when a write targets channel 3
//   tick_vga, tick_seg, tick_logic   registered one-cycle enables
//   logic_ticks  tick_logic pulses since the last start (wraps at 16 bits)
//   state        IDLE=0, RUN=1, PAUSE=2
module tick_scheduler #(
  parameter int DIV_W     = 24,
  parameter int VGA_DIV   = 3,
  parameter int SEG_DIV   = 262143,
  parameter int LOGIC_DIV = 4194303
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_pause,
  input  logic             cmd_resume,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             tick_vga,
  output logic             tick_seg,
  output logic             tick_logic,
  output logic [15:0]      logic_ticks,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           curState;
  logic [DIV_W-1:0] div     [3];
  logic [DIV_W-1:0] cnt     [3];
  logic [DIV_W-1:0] divNext [3];
  logic             tick    [3];

  logic cfgAccept;
  logic doStop;
  logic doStart;
  logic doPause;
  logic doResume;
  logic countEdge;

  assign state      = curState;
  assign tick_vga   = tick[0];
  assign tick_seg   = tick[1];
  assign tick_logic = tick[2];

  // Command decode. Priority is resolved on the raw pulses first (stop beats
  // start beats pause beats resume), then the winner is dropped if it is not
  // legal in the current state. The resume edge itself counts as a running
  // edge and the pause edge does not, so the number of frozen count edges
  // equals the number of cycles spent in PAUSE and the period is preserved.
  always_comb begin
    cfgAccept = cfg_valid && cfg_ready;
    doStop    = cmd_stop && (curState != IDLE);
    doStart   = cmd_start && !cmd_stop;
    doPause   = cmd_pause && !cmd_stop && !cmd_start && (curState == RUN);
    doResume  = cmd_resume && !cmd_stop && !cmd_start && !cmd_pause &&
                (curState == PAUSE);
    countEdge = ((curState == RUN) && !doStop && !doStart && !doPause) ||
                doResume;
  end

  // Divide values as they will be after this edge; a start sampled together
  // with a config write loads the freshly written value.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      divNext[i] = div[i];
      if (cfgAccept && (cfg_ch == 2'(i))) begin
        divNext[i] = cfg_div;
      end
    end
  end

  // Control FSM, config handshake and the logic-tick counter. cfg_ready
  // drops for exactly one cycle after every accepted write and comes up on
  // the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState    <= IDLE;
      cfg_ready   <= 1'b0;
      cfg_err     <= 1'b0;
      logic_ticks <= 16'd0;
    end else begin
      cfg_ready <= !cfgAccept;
      cfg_err   <= cfgAccept && (cfg_ch == 2'd3);
      if (doStop) begin
        curState <= IDLE;
      end else if (doStart) begin
        curState <= RUN;
      end else if (doPause) begin
        curState <= PAUSE;
      end else if (doResume) begin
        curState <= RUN;
      end
      if (doStart) begin
        logic_ticks <= 16'd0;
      end else if (countEdge && (cnt[2] == '0)) begin
        logic_ticks <= logic_ticks + 16'd1;
      end
    end
  end

  // Per-channel divide registers, down-counters and tick flops. Outside of
  // running edges the counters either follow the divide value (IDLE, stop,
  // start) or hold (PAUSE and the pause edge); ticks are only ever raised on
  // a running edge whose counter has reached zero. A running reload uses the
  // divide value from before this edge, so a write lands at the next reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div[0] <= DIV_W'(VGA_DIV);
      div[1] <= DIV_W'(SEG_DIV);
      div[2] <= DIV_W'(LOGIC_DIV);
      cnt[0] <= DIV_W'(VGA_DIV);
      cnt[1] <= DIV_W'(SEG_DIV);
      cnt[2] <= DIV_W'(LOGIC_DIV);
      for (int i = 0; i < 3; i++) begin
        tick[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        div[i] <= divNext[i];
        if (doStart || doStop || (curState == IDLE)) begin
          cnt[i]  <= divNext[i];
          tick[i] <= 1'b0;
        end else if (countEdge) begin
          if (cnt[i] == '0) begin
            cnt[i]  <= div[i];
            tick[i] <= 1'b1;
          end else begin
            cnt[i]  <= cnt[i] - 1'b1;
            tick[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler
//   Self-checking bench for tick_scheduler. A behavioural model tracks, per
//   channel, how many running edges have elapsed since the last load and the
//   period currently in force; every clock its predictions are compared with
//   all DUT outputs. A constant table covers the default vga cadence, and
//   hand-written sequences cover pause/resume, the config handshake, command
//   collisions, reset mid-run and the logic_ticks wrap.
module tb_tick_scheduler;

  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_start;
  logic             cmd_stop;
  logic             cmd_pause;
  logic             cmd_resume;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;
  logic             tick_vga;
  logic             tick_seg;
  logic             tick_logic;
  logic [15:0]      logic_ticks;
  logic [1:0]       state;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  int mState;
  int mDiv     [3];
  int mElapsed [3];
  int mTarget  [3];
  bit mTick    [3];
  int mTicks;
  bit mReady;
  bit mErr;

  typedef struct {
    bit       start;
    bit [1:0] expState;
    bit       expVga;
  } vec_t;
  vec_t vgaTable [13];

  always #5 clk = ~clk;

  tick_scheduler #(
    .DIV_W(DIV_W), .VGA_DIV(3), .SEG_DIV(5), .LOGIC_DIV(9)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_pause(cmd_pause), .cmd_resume(cmd_resume),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err),
    .tick_vga(tick_vga), .tick_seg(tick_seg), .tick_logic(tick_logic),
    .logic_ticks(logic_ticks), .state(state)
  );

  function automatic int defDiv(input int i);
    return (i == 0) ? 3 : (i == 1) ? 5 : 9;
  endfunction

  function automatic void modelReset();
    mState = 0;
    mTicks = 0;
    mReady = 1'b0;
    mErr   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mDiv[i]     = defDiv(i);
      mElapsed[i] = 0;
      mTarget[i]  = defDiv(i);
      mTick[i]    = 1'b0;
    end
  endfunction

  // One clock edge of the specified behaviour, from the inputs as sampled.
  // cmd: 0 none, 1 stop, 2 start, 3 pause, 4 resume.
  function automatic void modelEdge();
    bit accept;
    int newDiv [3];
    int cmd;
    bit counting;
    accept = cfg_valid && mReady;
    for (int i = 0; i < 3; i++) newDiv[i] = mDiv[i];
    if (accept && cfg_ch != 2'd3) newDiv[cfg_ch] = int'(cfg_div);
    cmd = 0;
    if (cmd_stop) cmd = (mState != 0) ? 1 : 0;
    else if (cmd_start) cmd = 2;
    else if (cmd_pause) cmd = (mState == 1) ? 3 : 0;
    else if (cmd_resume) cmd = (mState == 2) ? 4 : 0;
    counting = (mState == 1 && cmd == 0) || cmd == 4;
    for (int i = 0; i < 3; i++) begin
      mTick[i] = 1'b0;
      if (cmd == 2 || cmd == 1 || mState == 0) begin
        mElapsed[i] = 0;
        mTarget[i]  = newDiv[i];
      end else if (counting) begin
        if (mElapsed[i] == mTarget[i]) begin
          mTick[i]    = 1'b1;
          mElapsed[i] = 0;
          mTarget[i]  = mDiv[i];
        end else begin
          mElapsed[i]++;
        end
      end
    end
    if (cmd == 2) mTicks = 0;
    else if (mTick[2]) mTicks = (mTicks + 1) % 65536;
    case (cmd)
      1: mState = 0;
      2: mState = 1;
      3: mState = 2;
      4: mState = 1;
      default: ;
    endcase
    mErr   = accept && cfg_ch == 2'd3;
    mReady = !accept;
    for (int i = 0; i < 3; i++) mDiv[i] = newDiv[i];
  endfunction

  task automatic checkOutput(input string name);
    vectors++;
    if (state !== 2'(mState) || tick_vga !== mTick[0] || tick_seg !== mTick[1] ||
        tick_logic !== mTick[2] || logic_ticks !== 16'(mTicks) ||
        cfg_ready !== mReady || cfg_err !== mErr) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got state=%0d vga=%0b seg=%0b logic=%0b ticks=%0d ready=%0b err=%0b expected state=%0d vga=%0b seg=%0b logic=%0b ticks=%0d ready=%0b err=%0b",
               name, $time, state, tick_vga, tick_seg, tick_logic, logic_ticks,
               cfg_ready, cfg_err, mState, mTick[0], mTick[1], mTick[2], mTicks,
               mReady, mErr);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit stop, input bit pause,
                               input bit resume, input bit valid,
                               input int ch, input int div);
    cmd_start  = start;
    cmd_stop   = stop;
    cmd_pause  = pause;
    cmd_resume = resume;
    cfg_valid  = valid;
    cfg_ch     = 2'(ch);
    cfg_div    = DIV_W'(div);
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step(input string name);
    @(posedge clk);
    if (reset) modelReset();
    else modelEdge();
    #1;
    checkOutput(name);
  endtask

  initial begin
    bit found;
    bit seen65535;
    bit sawWrap;

    // Default vga cadence: start in cycle 0, ticks in cycles 5, 9, 13.
    for (int j = 0; j < 13; j++) begin
      vgaTable[j].start    = (j == 0);
      vgaTable[j].expState = 2'd1;
      vgaTable[j].expVga   = (j + 1 == 5) || (j + 1 == 9) || (j + 1 == 13);
    end

    reset = 1'b1;
    idleInputs();
    #2;
    modelReset();
    checkOutput("reset state");
    checkValue("reset cfg_ready", int'(cfg_ready), 0);
    step("reset held");
    step("reset held");
    reset = 1'b0;
    step("reset release");
    checkValue("ready after release", int'(cfg_ready), 1);
    checkValue("idle after release", int'(state), 0);

    for (int j = 0; j < 13; j++) begin
      applyStimulus(vgaTable[j].start, 0, 0, 0, 0, 0, 0);
      step("vga table model");
      checkValue("vga table state", int'(state), int'(vgaTable[j].expState));
      checkValue("vga table tick", int'(tick_vga), int'(vgaTable[j].expVga));
    end
    idleInputs();

    // Pause and resume with div[0]=7.
    applyStimulus(0, 1, 0, 0, 1, 0, 7);
    step("stop+cfg div7");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    step("start div7");
    idleInputs();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step("wait first vga");
      if (tick_vga) found = 1'b1;
    end
    checkValue("first vga tick seen", int'(found), 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    step("pause");
    idleInputs();
    for (int k = 0; k < 10; k++) begin
      step("paused");
      checkValue("no tick in pause", int'(tick_vga), 0);
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    step("resume");
    idleInputs();
    for (int k = 0; k < 20; k++) step("after resume");

    // Handshake: valid held three cycles, then a write to channel 3.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    step("stop");
    checkValue("ready before burst", int'(cfg_ready), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 2);
    step("burst 1");
    checkValue("ready cycle 1", int'(cfg_ready), 0);
    step("burst 2");
    checkValue("ready cycle 2", int'(cfg_ready), 1);
    step("burst 3");
    checkValue("ready cycle 3", int'(cfg_ready), 0);
    idleInputs();
    step("burst idle");
    applyStimulus(0, 0, 0, 0, 1, 3, 11);
    step("cfg ch3");
    checkValue("cfg_err pulse", int'(cfg_err), 1);
    idleInputs();
    step("cfg ch3 after");
    checkValue("cfg_err cleared", int'(cfg_err), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    step("start after ch3");
    idleInputs();
    for (int k = 0; k < 12; k++) step("div unchanged run");

    // Collisions: stop+start in RUN, then start+cfg ch0 div=1.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    step("stop+start");
    checkValue("stop wins state", int'(state), 0);
    idleInputs();
    for (int k = 0; k < 4; k++) begin
      step("after stop+start");
      checkValue("no tick after stop", int'(tick_vga), 0);
    end
    applyStimulus(1, 0, 0, 0, 1, 0, 1);
    step("start+cfg cycle1");
    idleInputs();
    checkValue("vga cycle 1", int'(tick_vga), 0);
    step("start+cfg cycle2");
    checkValue("vga cycle 2", int'(tick_vga), 0);
    step("start+cfg cycle3");
    checkValue("vga cycle 3", int'(tick_vga), 1);

    // Reset mid-run just before a tick_logic.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step("toward logic tick");
      if (mElapsed[2] == mTarget[2] && mState == 1) found = 1'b1;
    end
    checkValue("logic tick imminent", int'(found), 1);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async reset");
    step("reset over logic edge");
    checkValue("no logic tick", int'(tick_logic), 0);
    reset = 1'b0;
    step("reset release 2");
    checkValue("ready after reset 2", int'(cfg_ready), 1);
    checkValue("logic_ticks cleared", int'(logic_ticks), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    step("restart defaults");
    idleInputs();
    for (int k = 0; k < 12; k++) step("default divs");

    // Randomized commands and config writes against the model.
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 99);
      applyStimulus(r < 3, r >= 3 && r < 5, r >= 5 && r < 9, r >= 9 && r < 14,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 12));
      step("random");
    end
    idleInputs();

    // logic_ticks wrap with div[2]=0.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    step("wrap stop");
    step("wrap idle");
    applyStimulus(0, 0, 0, 0, 1, 2, 0);
    step("wrap cfg");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    step("wrap start");
    idleInputs();
    seen65535 = 1'b0;
    sawWrap   = 1'b0;
    for (int k = 0; k < 65545; k++) begin
      step("wrap");
      if (logic_ticks == 16'd65535) seen65535 = 1'b1;
      else if (seen65535 && logic_ticks == 16'd0) sawWrap = 1'b1;
    end
    checkValue("logic_ticks wrapped", int'(sawWrap), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
